// File: rtl/vctcxo_ctrl_pkg.sv
// Shared constants, FSM state type and frame builder for the VCTCXO trim DAC path.
package vctcxo_ctrl_pkg;

    localparam int unsigned DAC_FRAME_BITS = 24;
    localparam logic [1:0]  DAC_PD_NORMAL  = 2'b00;

    localparam logic DAC_MODE_MANUAL = 1'b1;
    localparam logic DAC_MODE_LOOP   = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } dac_state_t;

    // AD5660 write word: 6 don't-care zeros, power-down bits, 16-bit code.
    function automatic logic [DAC_FRAME_BITS-1:0] dac_frame(input logic [15:0] code);
        return {6'b000000, DAC_PD_NORMAL, code};
    endfunction

endpackage

// File: rtl/ad5660_spi_tx.sv
// AD5660 SPI frame transmitter: one 24-bit MSB-first write per start pulse.
module ad5660_spi_tx
    import vctcxo_ctrl_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [15:0] i_code,
    output logic        o_done,
    output logic        o_busy,
    output logic        o_sclk,
    output logic        o_sync_n,
    output logic        o_din
);

    localparam int unsigned DIV_W = $clog2(2 * SCLK_DIV);
    localparam int unsigned BIT_W = $clog2(DAC_FRAME_BITS);

    logic [DAC_FRAME_BITS-1:0] r_shift;
    logic [DIV_W-1:0]          r_div_cnt;
    logic [BIT_W-1:0]          r_bit_cnt;
    logic                      r_active;
    logic                      r_sclk;
    logic                      r_sync_n;
    logic                      r_din;
    logic                      w_bit_end;
    logic                      w_last;

    assign w_bit_end = r_active && (r_div_cnt == DIV_W'(2 * SCLK_DIV - 1));
    assign w_last    = w_bit_end && (r_bit_cnt == BIT_W'(DAC_FRAME_BITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_active  <= 1'b0;
            r_sclk    <= 1'b1;
            r_sync_n  <= 1'b1;
            r_din     <= 1'b0;
        end else if (!r_active) begin
            if (i_start) begin
                r_shift   <= dac_frame(i_code) << 1;
                r_din     <= dac_frame(i_code) >> (DAC_FRAME_BITS - 1);
                r_div_cnt <= '0;
                r_bit_cnt <= '0;
                r_active  <= 1'b1;
                r_sclk    <= 1'b1;
                r_sync_n  <= 1'b0;
            end
        end else if (w_last) begin
            r_active <= 1'b0;
            r_sync_n <= 1'b1;
            r_sclk   <= 1'b1;
            r_din    <= 1'b0;
        end else if (w_bit_end) begin
            // DIN only moves with the rising SCLK so it is stable at the DAC's falling-edge sample.
            r_div_cnt <= '0;
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            r_sclk    <= 1'b1;
            r_din     <= r_shift[DAC_FRAME_BITS-1];
            r_shift   <= r_shift << 1;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
            if (r_div_cnt == DIV_W'(SCLK_DIV - 1)) begin
                r_sclk <= 1'b0;
            end
        end
    end

    assign o_done   = w_last;
    assign o_busy   = r_active;
    assign o_sclk   = r_sclk;
    assign o_sync_n = r_sync_n;
    assign o_din    = r_din;

endmodule

// File: rtl/vctcxo_dac_ctrl.sv
// VCTCXO trim DAC controller: manual/loop code arbitration, write pacing,
// lock detection and HOLD sequencing around the AD5660 SPI transmitter.
module vctcxo_dac_ctrl
    import vctcxo_ctrl_pkg::*;
#(
    parameter int unsigned SCLK_DIV     = 4,
    parameter int unsigned MIN_INTERVAL = 1000,
    parameter int unsigned LOCK_TOL     = 8,
    parameter int unsigned LOCK_COUNT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dac_mode,
    input  logic [15:0] dac_user_set_value,
    input  logic        loop_valid,
    input  logic [15:0] loop_value,
    output logic        loop_ready,
    output logic [15:0] dac_value,
    output logic        dac_locked,
    output logic        busy,
    output logic        spi_sclk,
    output logic        spi_sync_n,
    output logic        spi_din
);

    localparam int unsigned INT_W  = $clog2(MIN_INTERVAL + 1);
    localparam int unsigned LOCK_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned HOLD_W = $clog2(SCLK_DIV);

    dac_state_t        r_state;
    dac_state_t        w_state_next;
    logic [INT_W-1:0]  r_interval;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic [LOCK_W-1:0] w_lock_cnt_next;
    logic              r_locked;
    logic              r_seeded;
    logic              r_force_write;
    logic              r_mode_prev;
    logic [15:0]       r_frame_code;
    logic              r_frame_is_loop;
    logic [15:0]       r_dac_value;
    logic              r_busy;

    logic              w_interval_done;
    logic              w_loop_ready;
    logic              w_start;
    logic              w_start_is_loop;
    logic [15:0]       w_start_code;
    logic              w_mode_change;
    logic              w_tx_done;
    logic              w_tx_busy;
    logic signed [16:0] w_delta;
    logic [16:0]       w_delta_mag;
    logic              w_in_tol;

    // The counter reloads to 0 on the start edge, so reaching MIN_INTERVAL-1 means the
    // next edge is exactly MIN_INTERVAL cycles after the previous frame start.
    assign w_interval_done = (r_interval >= INT_W'(MIN_INTERVAL - 1));

    always_comb begin
        w_state_next    = r_state;
        w_loop_ready    = 1'b0;
        w_start         = 1'b0;
        w_start_is_loop = 1'b0;
        w_start_code    = dac_user_set_value;
        w_mode_change   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!rst && !w_tx_busy) begin
                    if (dac_mode != r_mode_prev) begin
                        w_mode_change = 1'b1;
                    end else if (dac_mode == DAC_MODE_MANUAL) begin
                        w_start = r_force_write || (dac_user_set_value != r_dac_value);
                    end else begin
                        w_loop_ready = w_interval_done;
                        if (w_interval_done && loop_valid) begin
                            w_start         = 1'b1;
                            w_start_is_loop = 1'b1;
                            w_start_code    = loop_value;
                        end
                    end
                end
                if (w_start) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_tx_done) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt == HOLD_W'(SCLK_DIV - 1)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_delta     = $signed({1'b0, r_frame_code}) - $signed({1'b0, r_dac_value});
        w_delta_mag = w_delta[16] ? $unsigned(-w_delta) : $unsigned(w_delta);
        w_in_tol    = (w_delta_mag <= 17'(LOCK_TOL));
        if (!r_seeded || !w_in_tol) begin
            w_lock_cnt_next = '0;
        end else if (r_lock_cnt == LOCK_W'(LOCK_COUNT)) begin
            w_lock_cnt_next = r_lock_cnt;
        end else begin
            w_lock_cnt_next = r_lock_cnt + LOCK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_interval      <= INT_W'(MIN_INTERVAL);
            r_hold_cnt      <= '0;
            r_lock_cnt      <= '0;
            r_locked        <= 1'b0;
            r_seeded        <= 1'b0;
            r_force_write   <= 1'b1;
            r_mode_prev     <= dac_mode;
            r_frame_code    <= '0;
            r_frame_is_loop <= 1'b0;
            r_dac_value     <= '0;
            r_busy          <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != ST_IDLE);

            if (w_start) begin
                r_interval <= '0;
            end else if (r_interval != INT_W'(MIN_INTERVAL)) begin
                r_interval <= r_interval + INT_W'(1);
            end

            r_hold_cnt <= (r_state == ST_HOLD) ? r_hold_cnt + HOLD_W'(1) : '0;

            if (w_start) begin
                r_frame_code    <= w_start_code;
                r_frame_is_loop <= w_start_is_loop;
                r_force_write   <= 1'b0;
            end

            if (w_mode_change) begin
                r_mode_prev <= dac_mode;
                r_lock_cnt  <= '0;
                r_locked    <= 1'b0;
                r_seeded    <= 1'b0;
                if (dac_mode == DAC_MODE_MANUAL) begin
                    r_force_write <= 1'b1;
                end
            end

            if (w_tx_done) begin
                r_dac_value <= r_frame_code;
                if (r_frame_is_loop) begin
                    r_lock_cnt <= w_lock_cnt_next;
                    r_locked   <= (w_lock_cnt_next == LOCK_W'(LOCK_COUNT));
                    r_seeded   <= 1'b1;
                end
            end
        end
    end

    ad5660_spi_tx #(
        .SCLK_DIV (SCLK_DIV)
    ) u_spi_tx (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_code   (w_start_code),
        .o_done   (w_tx_done),
        .o_busy   (w_tx_busy),
        .o_sclk   (spi_sclk),
        .o_sync_n (spi_sync_n),
        .o_din    (spi_din)
    );

    assign loop_ready = w_loop_ready;
    assign dac_value  = r_dac_value;
    assign dac_locked = r_locked;
    assign busy       = r_busy;

endmodule

// File: tb/tb_vctcxo_dac_ctrl.sv
// Scoreboard bench for vctcxo_dac_ctrl: randomized manual/loop traffic, SPI frame decode.
`timescale 1ns/1ps
module tb_vctcxo_dac_ctrl;

    localparam int unsigned SD        = 2;
    localparam int unsigned MIN_INT   = 200;
    localparam int unsigned TOL       = 8;
    localparam int unsigned LCNT      = 4;
    localparam int unsigned FRAME_LOW = 48 * SD;

    logic        clk = 1'b0;
    logic        rst;
    logic        dac_mode;
    logic [15:0] user;
    logic        loop_valid;
    logic [15:0] loop_value;
    logic        loop_ready;
    logic [15:0] dac_value;
    logic        dac_locked;
    logic        busy;
    logic        spi_sclk;
    logic        spi_sync_n;
    logic        spi_din;

    always #5 clk = ~clk;

    vctcxo_dac_ctrl #(
        .SCLK_DIV     (SD),
        .MIN_INTERVAL (MIN_INT),
        .LOCK_TOL     (TOL),
        .LOCK_COUNT   (LCNT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .dac_mode           (dac_mode),
        .dac_user_set_value (user),
        .loop_valid         (loop_valid),
        .loop_value         (loop_value),
        .loop_ready         (loop_ready),
        .dac_value          (dac_value),
        .dac_locked         (dac_locked),
        .busy               (busy),
        .spi_sclk           (spi_sclk),
        .spi_sync_n         (spi_sync_n),
        .spi_din            (spi_din)
    );

    typedef struct {
        logic [15:0] code;
        logic        locked;
        bit          gap_chk;
    } exp_t;

    exp_t  exp_q[$];
    int    loop_hist[$];
    int    n_checks      = 0;
    int    n_pass        = 0;
    int    frames_seen   = 0;
    int    frames_pushed = 0;
    int    ready_bad     = 0;
    longint cyc          = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic push_exp(input logic [15:0] code, input logic locked, input bit gap);
        exp_t e;
        e.code = code; e.locked = locked; e.gap_chk = gap;
        exp_q.push_back(e);
        frames_pushed++;
    endtask

    // Locked once the last LCNT consecutive loop-code steps since mode entry are all within TOL.
    function automatic logic model_locked();
        int n = loop_hist.size();
        if (n < int'(LCNT) + 1) return 1'b0;
        for (int i = n - int'(LCNT); i < n; i++) begin
            int d = loop_hist[i] - loop_hist[i-1];
            if (d < 0) d = -d;
            if (d > int'(TOL)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, longint'(n < budget), 1);
    endtask

    task automatic wait_sync(input logic lvl, input string name);
        int n = 0;
        while (spi_sync_n != lvl && n < 4 * FRAME_LOW) begin
            @(negedge clk);
            n++;
        end
        chk(name, spi_sync_n, lvl);
    endtask

    task automatic loop_frame(input logic [15:0] code, input bit gap);
        int n = 0;
        bit hs = 0;
        loop_value = code;
        loop_valid = 1'b1;
        while (!hs && n < int'(MIN_INT + 4 * FRAME_LOW)) begin
            #1;
            if (loop_ready) hs = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk("loop_handshake", hs, 1);
        if (hs) begin
            loop_hist.push_back(int'(code));
            push_exp(code, model_locked(), gap);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Monitor: decodes each SPI frame and compares it with the scoreboard head at SYNC rise.
    initial begin : monitor
        logic        prev_sync, prev_sclk;
        int          low_cnt, nbits;
        logic [23:0] bits;
        longint      start_cyc, last_start;
        exp_t        e;
        prev_sync = 1'b1; prev_sclk = 1'b1; low_cnt = 0; nbits = 0; bits = '0;
        start_cyc = 0; last_start = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                prev_sync = 1'b1;
                prev_sclk = 1'b1;
                continue;
            end
            if (prev_sync && !spi_sync_n) begin
                low_cnt = 0; nbits = 0; bits = '0; start_cyc = cyc;
            end
            if (!spi_sync_n) begin
                low_cnt++;
                if (prev_sclk && !spi_sclk) begin
                    bits = {bits[22:0], spi_din};
                    nbits++;
                end
            end
            if (!prev_sync && spi_sync_n) begin
                frames_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", frames_seen, frames_pushed);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_bits", bits, {8'h00, e.code});
                    chk("frame_nbits", nbits, 24);
                    chk("sync_low_cycles", low_cnt, FRAME_LOW);
                    chk("sclk_high_at_end", spi_sclk, 1);
                    chk("dac_value_at_end", dac_value, e.code);
                    chk("dac_locked_at_end", dac_locked, e.locked);
                    if (e.gap_chk) chk("loop_start_gap", start_cyc - last_start, MIN_INT);
                end
                last_start = start_cyc;
            end
            if (loop_ready && (dac_mode || busy)) ready_bad++;
            prev_sync = spi_sync_n;
            prev_sclk = spi_sclk;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        logic [15:0] v, v2, code;
        int d;
        rst = 1'b1; dac_mode = 1'b1; user = 16'd2300; loop_valid = 1'b0; loop_value = '0;
        repeat (3) @(negedge clk);
        chk("rst_sync_n", spi_sync_n, 1);
        chk("rst_sclk", spi_sclk, 1);
        chk("rst_din", spi_din, 0);
        chk("rst_loop_ready", loop_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dac_value", dac_value, 0);
        chk("rst_dac_locked", dac_locked, 0);

        // Forced write of the user value after reset, then silence.
        push_exp(16'd2300, 1'b0, 1'b0);
        rst = 1'b0;
        wait_idle("t1_idle", 2000);
        repeat (150) @(negedge clk);
        chk("t1_frame_count", frames_seen, 1);

        // Mid-frame and in-HOLD user changes: only the latest value is written afterwards.
        user = 16'd1234;
        push_exp(16'd1234, 1'b0, 1'b0);
        wait_sync(1'b0, "t2_frame_start");
        repeat (20) @(negedge clk);
        user = 16'd4000;
        wait_sync(1'b1, "t2_frame_end");
        user = 16'd5000;
        push_exp(16'd5000, 1'b0, 1'b0);
        wait_idle("t2_idle", 2000);
        chk("t2_dac_value", dac_value, 5000);
        chk("t2_frame_count", frames_seen, 3);

        v = 16'd5000;
        for (int i = 0; i < 6; i++) begin
            v2 = 16'($urandom_range(0, 65535));
            while (v2 == v) v2 = 16'($urandom_range(0, 65535));
            v = v2;
            user = v;
            push_exp(v, 1'b0, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                wait_sync(1'b0, "rnd_manual_start");
                repeat ($urandom_range(1, 60)) @(negedge clk);
                v2 = 16'($urandom_range(0, 65535));
                while (v2 == v) v2 = 16'($urandom_range(0, 65535));
                v = v2;
                user = v;
                push_exp(v, 1'b0, 1'b0);
            end
            wait_idle("rnd_manual_idle", 2000);
        end
        repeat (20) @(negedge clk);
        chk("rnd_manual_dac_value", dac_value, v);

        // Reset 40 cycles into a frame: aborted frame, then a full rewrite.
        v2 = v ^ 16'h5A5A;
        user = v2;
        wait_sync(1'b0, "t5_frame_start");
        repeat (40) @(negedge clk);
        rst = 1'b1;
        loop_hist.delete();
        @(negedge clk);
        chk("t5_sync_n", spi_sync_n, 1);
        chk("t5_sclk", spi_sclk, 1);
        chk("t5_dac_value", dac_value, 0);
        chk("t5_dac_locked", dac_locked, 0);
        chk("t5_busy", busy, 0);
        repeat (2) @(negedge clk);
        push_exp(v2, 1'b0, 1'b0);
        rst = 1'b0;
        wait_idle("t5_idle", 2000);
        chk("t5_rewrite_value", dac_value, v2);

        // Closed loop: paced frames, tolerance boundaries, a +100 jump, and relock.
        dac_mode = 1'b0;
        loop_hist.delete();
        code = 16'd30000;
        for (int i = 0; i < 18; i++) begin
            if (i == 3) d = 8;
            else if (i == 4) d = -8;
            else if (i == 6) d = 100;
            else if (i == 12) d = -9;
            else d = int'($urandom_range(0, 14)) - 7;
            code = 16'(int'(code) + d);
            loop_frame(code, i > 0);
        end
        chk("t3_model_locked_before_switch", dac_locked, 1);

        // Switch to manual mid-frame with user == code being written: frame completes, rewrite forced.
        repeat (10) @(negedge clk);
        chk("t6_frame_in_flight", spi_sync_n, 0);
        dac_mode = 1'b1;
        user = code;
        loop_valid = 1'b0;
        loop_hist.delete();
        push_exp(code, 1'b0, 1'b0);
        wait_idle("t6_idle", 4000);
        chk("t6_dac_locked", dac_locked, 0);
        chk("t6_dac_value", dac_value, code);

        repeat (300) @(negedge clk);
        chk("ready_violations", ready_bad, 0);
        chk("frames_total", frames_seen, frames_pushed);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
